freq_meter: RTL

Gated-count frequency meter that measures an external or looped-back waveform and reports its frequency in Hz. It is the receive-side counterpart of the sweep controller: the sweep block turns a frequency number into a waveform, and this block turns a waveform back into a frequency number. It is used for on-board closed-loop checking of sweep trajectories and pulse-mode output. It sits after the output stage (or on an input pin) and feeds the status/display path.

---
 rtl/freq_meter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Gated-count frequency meter: counts sig_in rising edges over a selectable gate and scales to Hz.
// Optional min/max trackers are built when FREQ_METER_MINMAX_EN is defined.
module freq_meter #(
    parameter int GATE_1MS_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sig_in,
    input  logic        enable,
    input  logic        start,
    input  logic        continuous,
    input  logic [1:0]  gate_sel,
    input  logic        minmax_clr,
    output logic [21:0] freq_hz,
    output logic        freq_valid,
    output logic        overflow,
    output logic        busy,
    output logic [21:0] min_hz,
    output logic [21:0] max_hz
);

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        SCALE,
        DONE
    } state_t;

    localparam logic [26:0] LEN_1MS   = 27'(GATE_1MS_CYCLES);
    localparam logic [26:0] LEN_10MS  = 27'(GATE_1MS_CYCLES * 10);
    localparam logic [26:0] LEN_100MS = 27'(GATE_1MS_CYCLES * 100);
    localparam logic [26:0] LEN_1S    = 27'(GATE_1MS_CYCLES * 1000);
    localparam logic [35:0] SAT_HZ    = 36'd4194303;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  sync_q;
    logic        edge_q;
    logic [26:0] gate_cnt;
    logic [26:0] gate_len;
    logic [1:0]  gate_code;
    logic [25:0] edge_cnt;
    logic [35:0] ext;
    logic [35:0] prod;
    logic [35:0] product_q;
    logic        gate_start;

    // sync_q[1] is the synchronized level, sync_q[2] its one-cycle delay
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], sig_in};
            edge_q <= sync_q[1] & ~sync_q[2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (enable && (start || continuous)) begin
                    state_nxt = GATE;
                end
            end
            GATE: begin
                if (gate_cnt == gate_len - 27'd1) begin
                    state_nxt = SCALE;
                end
            end
            SCALE: state_nxt = DONE;
            DONE: begin
                if (enable && continuous) begin
                    state_nxt = GATE;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt = IDLE;
        end
    end

    assign gate_start = (state_nxt == GATE) && (state != GATE);

    always_comb begin
        ext = {10'd0, edge_cnt};
        unique case (gate_code)
            2'd0:    prod = (ext << 10) - (ext << 4) - (ext << 3);
            2'd1:    prod = (ext << 6) + (ext << 5) + (ext << 2);
            2'd2:    prod = (ext << 3) + (ext << 1);
            default: prod = ext;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            gate_len   <= LEN_1MS;
            gate_code  <= 2'd0;
            edge_cnt   <= '0;
            product_q  <= '0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (gate_start) begin
                gate_cnt  <= '0;
                edge_cnt  <= '0;
                gate_code <= gate_sel;
                unique case (gate_sel)
                    2'd0:    gate_len <= LEN_1MS;
                    2'd1:    gate_len <= LEN_10MS;
                    2'd2:    gate_len <= LEN_100MS;
                    default: gate_len <= LEN_1S;
                endcase
            end else if (state == GATE) begin
                gate_cnt <= gate_cnt + 27'd1;
                if (edge_q && (edge_cnt != '1)) begin
                    edge_cnt <= edge_cnt + 26'd1;
                end
            end
            // An abort during SCALE keeps the previous result untouched
            if ((state == SCALE) && enable) begin
                product_q  <= prod;
                freq_valid <= 1'b1;
            end
        end
    end

    assign overflow = product_q > SAT_HZ;
    assign freq_hz  = overflow ? 22'h3FFFFF : product_q[21:0];
    assign busy     = state != IDLE;

`ifdef FREQ_METER_MINMAX_EN
    logic [21:0] min_q;
    logic [21:0] max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= 22'h3FFFFF;
            max_q <= '0;
        end else if (freq_valid) begin
            if (minmax_clr || (freq_hz < min_q)) begin
                min_q <= freq_hz;
            end
            if (minmax_clr || (freq_hz > max_q)) begin
                max_q <= freq_hz;
            end
        end else if (minmax_clr) begin
            min_q <= 22'h3FFFFF;
            max_q <= '0;
        end
    end

    assign min_hz = min_q;
    assign max_hz = max_q;
`else
    logic unused_clr;
    assign unused_clr = minmax_clr;
    assign min_hz     = '0;
    assign max_hz     = '0;
`endif

endmodule
